// File: rtl/dsam_decoder_if.sv
// rtl/dsam_decoder_if.sv - encoded-word input and decoded-word output bundle for dsam_decoder
interface dsam_decoder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 2
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in;
    logic                  resync;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out;
    logic [CH_W-1:0]       out_channel;

    modport master (
        output in_valid, in, resync,
        input  out_valid, out, out_channel
    );

    modport slave (
        input  in_valid, in, resync,
        output out_valid, out, out_channel
    );
endinterface

// File: rtl/dsam_decoder.sv
// rtl/dsam_decoder.sv - per-channel XOR differential decoder with round-robin channel rotation
module dsam_decoder #(
    parameter  int DATA_WIDTH = 16,
    parameter  int CHANNELS   = 4,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    dsam_decoder_if.slave  bus
);
    logic [DATA_WIDTH-1:0] h_q [CHANNELS];
    logic [CH_W-1:0]       ch_q;
    logic [CH_W-1:0]       ch_d;
    logic [DATA_WIDTH-1:0] dec_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic [CH_W-1:0]       out_ch_q;
    logic                  out_valid_q;

    assign bus.out         = out_q;
    assign bus.out_channel = out_ch_q;
    assign bus.out_valid   = out_valid_q;

    // Wrap compares against CHANNELS-1 so non-power-of-two counts cycle correctly.
    always_comb begin
        dec_d = bus.in ^ h_q[ch_q];
        ch_d  = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                h_q[i] <= '0;
            end
            ch_q        <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.resync) begin
            // Restart drops the concurrent word; out/out_channel keep their last value.
            for (int i = 0; i < CHANNELS; i++) begin
                h_q[i] <= '0;
            end
            ch_q        <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            h_q[ch_q]   <= dec_d;
            ch_q        <= ch_d;
            out_q       <= dec_d;
            out_ch_q    <= ch_q;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dsam_decoder.sv
// tb/tb_dsam_decoder.sv - directed scoreboard bench for dsam_decoder (4- and 3-channel instances)
module tb_dsam_decoder;
    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;

    logic [17:0] q4 [$];
    logic [17:0] q3 [$];

    dsam_decoder_if #(.DATA_WIDTH(16), .CH_W(2)) a ();
    dsam_decoder_if #(.DATA_WIDTH(16), .CH_W(2)) b ();

    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(a));
    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the 4-channel instance; exp_v pushes the expected word.
    task automatic step4(input string tag, input logic rst, input logic v, input logic [15:0] d,
                         input logic rs, input logic exp_v, input logic [15:0] exp_d,
                         input logic [1:0] exp_c, input logic [15:0] hold_d, input logic [1:0] hold_c);
        logic [17:0] e;
        reset      = rst;
        a.in_valid = v;
        a.in       = d;
        a.resync   = rs;
        if (exp_v) q4.push_back({exp_c, exp_d});
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {15'd0, a.out_valid}, {15'd0, exp_v});
        if (a.out_valid === 1'b1) begin
            if (q4.size() == 0) begin
                chk({tag, ".unexpected"}, 16'd1, 16'd0);
            end else begin
                e = q4.pop_front();
                chk({tag, ".out"}, a.out, e[15:0]);
                chk({tag, ".ch"}, {14'd0, a.out_channel}, {14'd0, e[17:16]});
            end
        end else begin
            chk({tag, ".hold_out"}, a.out, hold_d);
            chk({tag, ".hold_ch"}, {14'd0, a.out_channel}, {14'd0, hold_c});
        end
    endtask

    task automatic step3(input string tag, input logic v, input logic [15:0] d,
                         input logic [15:0] exp_d, input logic [1:0] exp_c);
        logic [17:0] e;
        b.in_valid = v;
        b.in       = d;
        b.resync   = 1'b0;
        if (v) q3.push_back({exp_c, exp_d});
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {15'd0, b.out_valid}, {15'd0, v});
        if (b.out_valid === 1'b1 && q3.size() != 0) begin
            e = q3.pop_front();
            chk({tag, ".out"}, b.out, e[15:0]);
            chk({tag, ".ch"}, {14'd0, b.out_channel}, {14'd0, e[17:16]});
        end
    endtask

    initial begin
        reset      = 1'b1;
        a.in_valid = 1'b0;
        a.in       = '0;
        a.resync   = 1'b0;
        b.in_valid = 1'b0;
        b.in       = '0;
        b.resync   = 1'b0;

        // Reset held with a live word present, then one idle cycle after release.
        step4("rst0", 1, 1, 16'hFFFF, 0, 0, 16'h0, 2'd0, 16'h0000, 2'd0);
        step4("rst1", 1, 1, 16'hFFFF, 0, 0, 16'h0, 2'd0, 16'h0000, 2'd0);
        step4("rel",  0, 0, 16'hFFFF, 0, 0, 16'h0, 2'd0, 16'h0000, 2'd0);

        step4("z0", 0, 1, 16'h0001, 0, 1, 16'h0001, 2'd0, 16'h0, 2'd0);
        step4("z1", 0, 1, 16'h0002, 0, 1, 16'h0002, 2'd1, 16'h0, 2'd0);
        step4("z2", 0, 1, 16'h0003, 0, 1, 16'h0003, 2'd2, 16'h0, 2'd0);
        step4("z3", 0, 1, 16'h0004, 0, 1, 16'h0004, 2'd3, 16'h0, 2'd0);

        step4("d0", 0, 1, 16'h0004, 0, 1, 16'h0005, 2'd0, 16'h0, 2'd0);
        step4("d1", 0, 1, 16'h0004, 0, 1, 16'h0006, 2'd1, 16'h0, 2'd0);
        step4("d2", 0, 1, 16'h0004, 0, 1, 16'h0007, 2'd2, 16'h0, 2'd0);
        step4("d3", 0, 1, 16'h000C, 0, 1, 16'h0008, 2'd3, 16'h0, 2'd0);

        step4("bub0", 0, 0, 16'hDEAD, 0, 0, 16'h0, 2'd0, 16'h0008, 2'd3);
        step4("bub1", 0, 0, 16'hBEEF, 0, 0, 16'h0, 2'd0, 16'h0008, 2'd3);
        step4("bubw", 0, 1, 16'h0001, 0, 1, 16'h0004, 2'd0, 16'h0, 2'd0);

        step4("pre1", 0, 1, 16'h0000, 0, 1, 16'h0006, 2'd1, 16'h0, 2'd0);
        step4("rsy",  0, 1, 16'h1234, 1, 0, 16'h0, 2'd0, 16'h0006, 2'd1);
        step4("rs0",  0, 1, 16'h00AA, 0, 1, 16'h00AA, 2'd0, 16'h0, 2'd0);
        step4("rs1",  0, 1, 16'h00FF, 0, 1, 16'h00FF, 2'd1, 16'h0, 2'd0);

        // Mid-stream reset discards its word; the next word restarts on channel 0.
        step4("mrst", 1, 1, 16'h5555, 0, 0, 16'h0, 2'd0, 16'h0000, 2'd0);
        step4("mr0",  0, 1, 16'h0003, 0, 1, 16'h0003, 2'd0, 16'h0, 2'd0);
        a.in_valid = 1'b0;

        step3("c3_0", 1, 16'h0010, 16'h0010, 2'd0);
        step3("c3_1", 1, 16'h0020, 16'h0020, 2'd1);
        step3("c3_2", 1, 16'h0030, 16'h0030, 2'd2);
        step3("c3_3", 1, 16'h0001, 16'h0011, 2'd0);
        step3("c3_4", 1, 16'h0002, 16'h0022, 2'd1);
        step3("c3_i", 0, 16'h0000, 16'h0000, 2'd0);

        chk("q4_empty", 16'(q4.size()), 16'd0);
        chk("q3_empty", 16'(q3.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
